// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// one transaction at a time with a fixed read latency; data has priority.
module mem_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MEM_LATENCY     = 1,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int CNT_W = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
  localparam int ST_W  = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  state_t            state, state_nxt;
  owner_t            owner, owner_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ST_W-1:0]   streak, streak_nxt;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              ret, issue_opp, pick_if;

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    cnt_nxt    = cnt;
    streak_nxt = streak;

    // Return cycle doubles as an issue slot so back-to-back traffic has no gap.
    ret       = (state == BUSY) && (cnt == CNT_W'(1));
    issue_opp = (state == IDLE) || ret;
    pick_if   = if_req && (!d_req || (streak == ST_W'(MAX_DATA_STREAK)));

    if_gnt    = issue_opp && pick_if;
    d_gnt     = issue_opp && d_req && !pick_if;
    mem_en    = if_gnt || d_gnt;
    mem_addr  = d_gnt ? d_addr : if_addr;
    mem_we    = (d_gnt && d_we) ? d_wmask : '0;
    mem_wdata = d_wdata;

    if_rvalid = ret && (owner == OWN_IF);
    d_rvalid  = ret && (owner == OWN_D);
    if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
    d_rdata   = d_rvalid ? mem_rdata : d_rdata_q;
    busy      = (state == BUSY);

    if (state == BUSY) cnt_nxt = cnt - CNT_W'(1);
    if (ret) state_nxt = IDLE;
    if (mem_en) begin
      state_nxt = BUSY;
      owner_nxt = d_gnt ? OWN_D : OWN_IF;
      cnt_nxt   = CNT_W'(MEM_LATENCY);
    end

    // Streak counts data wins only while fetch is actually waiting.
    if (if_gnt)     streak_nxt = '0;
    else if (d_gnt) streak_nxt = if_req ? streak + ST_W'(1) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      cnt        <= '0;
      streak     <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      cnt    <= cnt_nxt;
      streak <= streak_nxt;
      if (if_rvalid) if_rdata_q <= mem_rdata;
      if (d_rvalid)  d_rdata_q  <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance at latency 1 with a byte-lane memory
// model, one at latency 3 with an address-derived read pipeline.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_wmask;

  logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, mem_en1, busy1;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic [3:0]  mem_we1;
  logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_en3, busy3;
  logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic [3:0]  mem_we3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req && !sel), .if_addr(if_addr), .if_gnt(if_gnt1),
    .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .d_req(d_req && !sel), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
  );

  mem_port_arbiter #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .if_req(if_req && sel), .if_addr(if_addr), .if_gnt(if_gnt3),
    .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .d_req(d_req && sel), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3)
  );

  // Latency-1 memory: read returns the pre-write word one cycle after issue.
  logic [31:0] mem1 [logic [31:0]];
  logic [31:0] rd1;
  assign mem_rdata1 = rd1;
  always @(posedge clk) begin
    logic [31:0] cur;
    if (mem_en1) begin
      cur = mem1.exists(mem_addr1) ? mem1[mem_addr1] : 32'h0;
      rd1 <= cur;
      for (int b = 0; b < 4; b++)
        if (mem_we1[b]) cur[8*b +: 8] = mem_wdata1[8*b +: 8];
      mem1[mem_addr1] = cur;
    end
  end

  // Latency-3 memory: word read at address A is ~A.
  logic [31:0] p0, p1, p2;
  assign mem_rdata3 = p2;
  always @(posedge clk) begin
    p0 <= mem_en3 ? ~mem_addr3 : 32'h0;
    p1 <= p0;
    p2 <= p1;
  end

  logic [31:0] if_q[$];
  logic [32:0] d_q[$];   // {check_data, data}; stores carry no data check

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    if (if_rvalid1) begin
      if (if_q.size() == 0) chk("if_rvalid_unexpected", 1, 0);
      else chk("if_rdata", if_rdata1, if_q.pop_front());
    end
    if (d_rvalid1) begin
      if (d_q.size() == 0) chk("d_rvalid_unexpected", 1, 0);
      else begin
        e = d_q.pop_front();
        if (e[32]) chk("d_rdata", d_rdata1, e[31:0]);
      end
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, "_mem_en"}, {mem_en1, mem_en3}, 0);
    chk({tag, "_mem_we"}, {mem_we1, mem_we3}, 0);
    chk({tag, "_gnt"}, {if_gnt1, d_gnt1, if_gnt3, d_gnt3}, 0);
    chk({tag, "_rvalid"}, {if_rvalid1, d_rvalid1, if_rvalid3, d_rvalid3}, 0);
    chk({tag, "_busy"}, {busy1, busy3}, 0);
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_wmask;
    logic        e_if_gnt, e_d_gnt, e_mem_en;
    logic [3:0]  e_mem_we;
    logic [31:0] e_mem_addr, e_rd;
    logic        e_chk;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 32'h1000, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0,
                1'b1, 1'b0, 1'b1, 4'h0, 32'h1000, 32'h00500093, 1'b1};
    vecs[1] = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h2004, 32'hDEADBEEF, 4'hF,
                1'b0, 1'b1, 1'b1, 4'hF, 32'h2004, 32'h0,        1'b0};
    vecs[2] = '{1'b0, 32'h0,    1'b1, 1'b0, 32'h2004, 32'h0,        4'h0,
                1'b0, 1'b1, 1'b1, 4'h0, 32'h2004, 32'hDEADBEEF, 1'b1};
    vecs[3] = '{1'b1, 32'h1000, 1'b1, 1'b0, 32'h3000, 32'h0,        4'h0,
                1'b0, 1'b1, 1'b1, 4'h0, 32'h3000, 32'h12345678, 1'b1};
    vecs[4] = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h3000, 32'hAAAABBBB, 4'h3,
                1'b0, 1'b1, 1'b1, 4'h3, 32'h3000, 32'h0,        1'b0};
    vecs[5] = '{1'b0, 32'h0,    1'b1, 1'b0, 32'h3000, 32'h0,        4'h0,
                1'b0, 1'b1, 1'b1, 4'h0, 32'h3000, 32'h1234BBBB, 1'b1};
    vecs[6] = '{1'b0, 32'h0,    1'b0, 1'b1, 32'h3000, 32'h55,       4'hF,
                1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0};
    vecs[7] = '{1'b1, 32'h3000, 1'b0, 1'b1, 32'h0,    32'h0,        4'hF,
                1'b1, 1'b0, 1'b1, 4'h0, 32'h3000, 32'h1234BBBB, 1'b1};

    mem1[32'h1000] = 32'h00500093;
    mem1[32'h3000] = 32'h12345678;
    reset = 1'b1; sel = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_wmask = '0;

    #100 check_idle("in_reset");
    #100 reset = 1'b0;
    @(negedge clk);
    check_idle("after_reset");

    // Single-transaction vectors on the latency-1 instance.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      d_req = vecs[i].d_req; d_we = vecs[i].d_we; d_addr = vecs[i].d_addr;
      d_wdata = vecs[i].d_wdata; d_wmask = vecs[i].d_wmask;
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), {if_gnt1, d_gnt1}, {vecs[i].e_if_gnt, vecs[i].e_d_gnt});
      chk($sformatf("v%0d_mem_en", i), mem_en1, vecs[i].e_mem_en);
      chk($sformatf("v%0d_mem_we", i), mem_we1, vecs[i].e_mem_we);
      if (vecs[i].e_mem_en) begin
        chk($sformatf("v%0d_mem_addr", i), mem_addr1, vecs[i].e_mem_addr);
        chk($sformatf("v%0d_mem_wdata", i), mem_wdata1, vecs[i].d_wdata);
      end
      if (vecs[i].e_if_gnt) if_q.push_back(vecs[i].e_rd);
      if (vecs[i].e_d_gnt)  d_q.push_back({vecs[i].e_chk, vecs[i].e_rd});
      @(posedge clk); #1;
      if_req = 1'b0; d_req = 1'b0;
      @(posedge clk);
    end

    // Contention: both held for 12 cycles; fetch forced after four data wins.
    #1;
    if_req = 1'b1; if_addr = 32'h1000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("cont%0d_gnt", i), {if_gnt1, d_gnt1},
          (i % 5 == 4) ? 2'b10 : 2'b01);
      if (i % 5 == 4) if_q.push_back(32'h00500093);
      else            d_q.push_back({1'b1, 32'h1234BBBB});
      @(posedge clk);
    end
    #1;
    if_req = 1'b0; d_req = 1'b0;
    repeat (3) @(posedge clk);

    // Latency 3: back-to-back fetches on the second instance.
    #1;
    sel = 1'b1; if_req = 1'b1; if_addr = 32'h1000;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("l3_k%0d_gnt", k), if_gnt3, (k == 0) || (k == 3));
      chk($sformatf("l3_k%0d_rvalid", k), if_rvalid3, (k == 3) || (k == 6));
      chk($sformatf("l3_k%0d_busy", k), busy3, (k >= 1) && (k <= 6));
      if (k == 3) chk("l3_rdata0", if_rdata3, 32'hFFFFEFFF);
      if (k == 6) chk("l3_rdata1", if_rdata3, 32'hFFFFEFFB);
      if (k == 3) chk("l3_mem_addr1", mem_addr3, 32'h1004);
      @(posedge clk); #1;
      if (k == 0) if_addr = 32'h1004;
      if (k == 3) if_req = 1'b0;
    end

    // Reset one cycle after a load issue drops the transaction.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
    @(negedge clk);
    chk("rst_issue_gnt", d_gnt3, 1);
    @(posedge clk); #1;
    d_req = 1'b0; reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("rst_k%0d_rvalid_busy", k), {d_rvalid3, busy3}, 2'b00);
      @(posedge clk); #1;
      if (k == 2) reset = 1'b0;
    end
    d_req = 1'b1; d_addr = 32'h2010;
    @(negedge clk);
    chk("post_rst_gnt", {d_gnt3, mem_addr3}, {1'b1, 32'h2010});
    @(posedge clk); #1;
    d_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_k%0d_rvalid", k), d_rvalid3, k == 3);
      if (k == 3) chk("post_rst_rdata", d_rdata3, 32'hFFFFDFEF);
      @(posedge clk); #1;
    end

    repeat (2) @(posedge clk);
    chk("if_q_drained", if_q.size(), 0);
    chk("d_q_drained", d_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
